key_debounce: RTL and testbench

Conditions the raw push-button inputs before the time-set logic and the LCD page-select logic use them.
- Synchronises each raw key into the clk domain.
- Debounces each key independently.
- Emits single-cycle press, release and auto-repeat step pulses per key, plus a clean held level.
- Sits directly upstream of watch_set and lcd_display_list. Its step output replaces the raw sw_in bus at those consumers.

---
 rtl/key_debounce.sv | 171 +++++++++++++++++
 tb/tb_key_debounce.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Push-button conditioner: per-key 2-flop synchroniser, debounce FSM and
// registered press / release / auto-repeat step pulses plus a clean level.
module key_debounce #(
    parameter int N_KEYS       = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEB_CYCLES   = 500000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] sw_raw,
    output logic [N_KEYS-1:0] sw_level,
    output logic [N_KEYS-1:0] sw_press,
    output logic [N_KEYS-1:0] sw_release,
    output logic [N_KEYS-1:0] sw_step
);

    localparam int MAX_DR  = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int CNT_MAX = ((MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE) - 1;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    // Raw level seen when no key is pressed; also the synchroniser reset value.
    localparam logic [N_KEYS-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("key_debounce: DEB_CYCLES must be >= 2");
    end
    if (REPEAT_DELAY < 2) begin : g_bad_delay
        $error("key_debounce: REPEAT_DELAY must be >= 2");
    end
    if (REPEAT_RATE < 2) begin : g_bad_rate
        $error("key_debounce: REPEAT_RATE must be >= 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEB_DN,
        ST_HELD,
        ST_RPT,
        ST_DEB_UP
    } key_state_t;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] act;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= IDLE_RAW;
            sync2_q <= IDLE_RAW;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // act is 1 while the key is pressed, whatever the board polarity.
    assign act = sync2_q ^ IDLE_RAW;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_state_t       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             step_q, step_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                step_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                step_q    <= step_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            step_d    = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    level_d = 1'b0;
                    if (act[k]) begin
                        state_d = ST_DEB_DN;
                        cnt_d   = '0;
                    end
                end
                ST_DEB_DN: begin
                    if (!act[k]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        step_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!act[k]) begin
                        state_d = ST_DEB_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == RPT_DLY_LAST) begin
                        state_d = ST_RPT;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RPT: begin
                    if (!act[k]) begin
                        state_d = ST_DEB_UP;
                        cnt_d   = '0;
                    end else if (cnt_q == RPT_RATE_LAST) begin
                        cnt_d  = '0;
                        step_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DEB_UP: begin
                    // A bounce back to pressed restarts the repeat delay without a new press.
                    if (act[k]) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign sw_level[k]   = level_q;
        assign sw_press[k]   = press_q;
        assign sw_release[k] = release_q;
        assign sw_step[k]    = step_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios then random key activity, all
// compared each cycle against a run-length / hold-time model of the keys.
module tb_key_debounce;

    localparam int NK  = 4;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic          clk;
    logic          rst;
    logic [NK-1:0] sw_raw;
    logic [NK-1:0] sw_level;
    logic [NK-1:0] sw_press;
    logic [NK-1:0] sw_release;
    logic [NK-1:0] sw_step;

    key_debounce #(
        .N_KEYS(NK), .ACTIVE_LOW(1), .DEB_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .sw_level(sw_level),
        .sw_press(sw_press), .sw_release(sw_release), .sw_step(sw_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int tick_no = 0;

    // Model: raw pipeline, accepted level, length of disagreeing run, held time since anchor.
    logic [NK-1:0] m_s1 = '1;
    logic [NK-1:0] m_s2 = '1;
    bit            lvl[NK];
    int            run[NK];
    int            hold[NK];
    logic [NK-1:0] exp_level, exp_press, exp_release, exp_step;

    int press_cnt[NK];
    int rel_cnt[NK];
    int step_cnt[NK];

    task automatic model_edge(input logic [NK-1:0] raw, input logic r);
        logic [NK-1:0] a;
        int old_run;
        exp_press = '0; exp_release = '0; exp_step = '0;
        if (r) begin
            m_s1 = '1; m_s2 = '1;
            for (int k = 0; k < NK; k++) begin
                lvl[k] = 1'b0; run[k] = 0; hold[k] = 0;
            end
        end else begin
            a = ~m_s2;
            m_s2 = m_s1;
            m_s1 = raw;
            for (int k = 0; k < NK; k++) begin
                old_run = run[k];
                if (a[k] != lvl[k]) run[k] = run[k] + 1;
                else run[k] = 0;
                if (run[k] == DEB + 1) begin
                    lvl[k] = !lvl[k];
                    run[k] = 0;
                    if (lvl[k]) begin
                        exp_press[k] = 1'b1; exp_step[k] = 1'b1; hold[k] = 0;
                    end else begin
                        exp_release[k] = 1'b1;
                    end
                end else if (lvl[k] && a[k]) begin
                    if (old_run > 0) hold[k] = 0;
                    else begin
                        hold[k] = hold[k] + 1;
                        if (hold[k] == RD || (hold[k] > RD && (hold[k] - RD) % RR == 0))
                            exp_step[k] = 1'b1;
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) exp_level[k] = lvl[k];
    endtask

    task automatic check_vec(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s tick %0d: got %b expected %b", tag, tick_no, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s tick %0d: got %0d expected %0d", tag, tick_no, got, exp);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NK; k++) begin
            press_cnt[k] = 0; rel_cnt[k] = 0; step_cnt[k] = 0;
        end
    endtask

    task automatic apply_stimulus(input logic [NK-1:0] raw, input logic r);
        @(negedge clk);
        sw_raw = raw;
        rst = r;
        @(posedge clk);
        model_edge(raw, r);
        tick_no++;
        #1;
        check_vec("level", sw_level, exp_level);
        check_vec("press", sw_press, exp_press);
        check_vec("release", sw_release, exp_release);
        check_vec("step", sw_step, exp_step);
        for (int k = 0; k < NK; k++) begin
            press_cnt[k] += int'(sw_press[k]);
            rel_cnt[k]   += int'(sw_release[k]);
            step_cnt[k]  += int'(sw_step[k]);
        end
    endtask

    int first_edge;
    int both_cnt;
    int rel3_early;
    logic [NK-1:0] rnd_raw;
    int remain[NK];

    initial begin
        rst = 1'b1;
        sw_raw = '1;

        // Key 0 held through reset: one press, 7th edge after rst falls.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(4'b1110, 1'b1);
            check_vec("in_reset", sw_level | sw_press | sw_release | sw_step, 4'b0000);
        end
        clear_counts();
        first_edge = 0;
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(4'b1110, 1'b0);
            if (sw_press[0] && first_edge == 0) first_edge = i;
        end
        check_int("rst_press_edge", first_edge, DEB + 3);
        check_int("rst_press_cnt", press_cnt[0], 1);
        check_int("rst_other_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b1111, 1'b0);

        // Clean tap on key 0.
        clear_counts();
        for (int i = 0; i < 8; i++) apply_stimulus(4'b1110, 1'b0);
        first_edge = 0;
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(4'b1111, 1'b0);
            if (sw_release[0] && first_edge == 0) first_edge = i;
        end
        check_int("tap_step_cnt", step_cnt[0], 1);
        check_int("tap_release_edge", first_edge, DEB + 3);
        check_int("tap_release_cnt", rel_cnt[0], 1);

        // Bounce rejection on key 1, then a real press.
        clear_counts();
        for (int i = 0; i < 20; i++) apply_stimulus((i / 2) % 2 == 0 ? 4'b1101 : 4'b1111, 1'b0);
        check_int("bounce_press_cnt", press_cnt[1], 0);
        for (int i = 0; i < 12; i++) apply_stimulus(4'b1101, 1'b0);
        check_int("bounce_then_press", press_cnt[1], 1);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b1111, 1'b0);

        // Auto-repeat on key 2.
        clear_counts();
        for (int i = 0; i < 30; i++) apply_stimulus(4'b1011, 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b1111, 1'b0);
        check_int("repeat_step_cnt", step_cnt[2], 7);
        check_int("repeat_release_cnt", rel_cnt[2], 1);

        // Release bounce on key 3.
        clear_counts();
        for (int i = 0; i < 20; i++) apply_stimulus(4'b0111, 1'b0);
        for (int i = 0; i < 2; i++) apply_stimulus(4'b1111, 1'b0);
        for (int i = 0; i < 15; i++) apply_stimulus(4'b0111, 1'b0);
        rel3_early = rel_cnt[3];
        check_int("relbounce_no_release", rel3_early, 0);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b1111, 1'b0);
        check_int("relbounce_one_release", rel_cnt[3], 1);

        // Keys 0 and 3 together, then reset during repeat.
        both_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(4'b0110, 1'b0);
            if (sw_press === 4'b1001) both_cnt++;
        end
        check_int("concurrent_press", both_cnt, 1);
        apply_stimulus(4'b0110, 1'b1);
        check_vec("rst_clear", sw_level | sw_press | sw_release | sw_step, 4'b0000);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0110, 1'b0);
        for (int i = 0; i < 12; i++) apply_stimulus(4'b1111, 1'b0);

        // Random key activity with occasional resets.
        rnd_raw = '1;
        for (int k = 0; k < NK; k++) remain[k] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (remain[k] == 0) begin
                    rnd_raw[k] = ~rnd_raw[k];
                    if ($urandom_range(0, 3) == 0) remain[k] = int'($urandom_range(15, 40));
                    else remain[k] = int'($urandom_range(1, 7));
                end
                remain[k]--;
            end
            apply_stimulus(rnd_raw, ($urandom_range(0, 299) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
